fetch_prefetch_buffer: RTL and testbench
========================================

FETCH_PREFETCH_BUFFER -- requirements
Module: fetch_prefetch_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: buffer entries; power of two, >= 2.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h00000000: fetch address after reset.
REQ-003 The block SHALL have parameter NOOP, default 32'h00000013: instruction presented when the buffer is empty.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of i_CLK.
REQ-005 The block SHALL have port i_CLK, input, 1 bit: clock.
REQ-006 The block SHALL have port i_RST, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port i_EN, input, 1 bit: fetch enable.
REQ-008 The block SHALL have port i_REDIRECT, input, 1 bit: flush buffer and load new PC.
REQ-009 The block SHALL have port i_REDIRECT_PC, input, 32 bits: redirect target.
REQ-010 The block SHALL have port o_INSTRUCTION_REQ, output, 1 bit: memory fetch request.
REQ-011 The block SHALL have port o_INSTRUCTION_ADDR, output, 32 bits: fetch address (current fetch PC).
REQ-012 The block SHALL have port i_INSTRUCTION_GNT, input, 1 bit: grant; i_INSTRUCTION is valid in the same cycle.
REQ-013 The block SHALL have port i_INSTRUCTION, input, 32 bits: fetched word.
REQ-014 The block SHALL have port i_INSTRUCTION_FETCH_NEXT, input, 1 bit: consumer pop request.
REQ-015 The block SHALL have port o_INSTRUCTION, output, 32 bits: head instruction, or NOOP when empty.
REQ-016 The block SHALL have port o_INSTRUCTION_PC, output, 32 bits: head instruction address, 0 when empty.
REQ-017 The block SHALL have port o_INSTRUCTION_VALID, output, 1 bit: buffer non-empty.
REQ-018 The block SHALL have port o_COUNT, output, clog2(DEPTH+1) bits: occupied entries.

Function
REQ-019 The block SHALL assert o_INSTRUCTION_REQ = i_EN & ~i_REDIRECT & (o_COUNT < DEPTH), combinationally.
REQ-020 The block SHALL push {fetch PC, i_INSTRUCTION} at the tail and advance fetch PC by 4 when req & gnt.
REQ-021 The fetch PC SHALL wrap modulo 2^32 (32'hFFFFFFFC + 4 = 0).
REQ-022 The block SHALL ignore i_INSTRUCTION_GNT while o_INSTRUCTION_REQ is low: no push, no PC change.
REQ-023 o_INSTRUCTION_VALID SHALL equal (o_COUNT != 0); o_INSTRUCTION and o_INSTRUCTION_PC SHALL show the head entry combinationally.
REQ-024 The block SHALL pop the head when i_INSTRUCTION_FETCH_NEXT & o_INSTRUCTION_VALID; a pop request while empty SHALL be ignored.
REQ-025 On a simultaneous push and pop, o_COUNT SHALL be unchanged, with both pointers advancing.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 When full, the request SHALL drop; a same-cycle pop SHALL NOT enable a push in that cycle, so refill resumes the next cycle.
REQ-028 On i_REDIRECT, the next cycle SHALL have o_COUNT = 0, pointers = 0, and fetch PC = {i_REDIRECT_PC[31:2], 2'b00}.
REQ-029 During i_REDIRECT, any grant or pop in that cycle SHALL be discarded.
REQ-030 With i_EN low, fetching SHALL stop; buffered entries SHALL remain poppable; fetch PC SHALL hold.
REQ-031 Fetch-to-consume latency SHALL be 1 cycle: a word granted in cycle N is at the head in cycle N+1 if the buffer was empty.

Reset
REQ-032 When i_RST is high at a clock edge, the block SHALL set fetch PC = RESET_PC, pointers = 0, and o_COUNT = 0.
REQ-033 Reset SHALL override redirect, push and pop in the same cycle.
REQ-034 In the cycle after reset, outputs SHALL be o_INSTRUCTION_VALID = 0, o_INSTRUCTION = NOOP, o_INSTRUCTION_PC = 0, o_INSTRUCTION_ADDR = RESET_PC, and o_INSTRUCTION_REQ = i_EN.
REQ-035 Reset asserted mid-operation SHALL discard all buffered entries.

Verification
REQ-036 Bench SHALL cover: reset, i_EN=1, GNT=1 every cycle, no pop -> ADDR 0,4,8,12; COUNT 1..4; REQ drops at COUNT=4; head = word@0.
REQ-037 Bench SHALL cover: full buffer, FETCH_NEXT=1 continuously with GNT=1 -> one-cycle refill gap after each drop, then the stream runs at PC order with no gaps or duplicates.
REQ-038 Bench SHALL cover: COUNT=2, REDIRECT=1 with REDIRECT_PC=32'h00000103, GNT=1, FETCH_NEXT=1 -> next cycle COUNT=0, ADDR=32'h00000100, VALID=0, o_INSTRUCTION=32'h00000013.
REQ-039 Bench SHALL cover: RESET_PC=32'hFFFFFFF8, two grants -> entry PCs FFFFFFF8 and FFFFFFFC, then ADDR=0.
REQ-040 Bench SHALL cover: GNT random 50%, FETCH_NEXT random, DEPTH=8 -> no overflow or underflow, pop order matches PC order, COUNT matches the scoreboard.
REQ-041 Bench SHALL cover: i_RST asserted with COUNT=3 alongside REDIRECT -> next cycle COUNT=0, ADDR=RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_buffer.sv
// fetch_prefetch_buffer: in-order instruction prefetch FIFO with redirect flush
module fetch_prefetch_buffer #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOOP = 32'h00000013,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          i_CLK,
  input  logic          i_RST,
  input  logic          i_EN,
  input  logic          i_REDIRECT,
  input  logic [31:0]   i_REDIRECT_PC,
  output logic          o_INSTRUCTION_REQ,
  output logic [31:0]   o_INSTRUCTION_ADDR,
  input  logic          i_INSTRUCTION_GNT,
  input  logic [31:0]   i_INSTRUCTION,
  input  logic          i_INSTRUCTION_FETCH_NEXT,
  output logic [31:0]   o_INSTRUCTION,
  output logic [31:0]   o_INSTRUCTION_PC,
  output logic          o_INSTRUCTION_VALID,
  output logic [CW-1:0] o_COUNT
);
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] ins_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0] fetch_pc;
  logic push, pop;
  // Request is gated on the registered count only, so a pop never frees a slot in the same cycle
  always_comb begin
    o_INSTRUCTION_REQ = i_EN & ~i_REDIRECT & (o_COUNT != CW'(DEPTH));
    push = o_INSTRUCTION_REQ & i_INSTRUCTION_GNT;
    o_INSTRUCTION_VALID = o_COUNT != '0;
    pop = i_INSTRUCTION_FETCH_NEXT & o_INSTRUCTION_VALID & ~i_REDIRECT;
    o_INSTRUCTION = o_INSTRUCTION_VALID ? ins_mem[rd_ptr] : NOOP;
    o_INSTRUCTION_PC = o_INSTRUCTION_VALID ? pc_mem[rd_ptr] : '0;
    o_INSTRUCTION_ADDR = fetch_pc;
  end
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      fetch_pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      o_COUNT <= '0;
    end else if (i_REDIRECT) begin
      fetch_pc <= {i_REDIRECT_PC[31:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      o_COUNT <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      o_COUNT <= o_COUNT + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge i_CLK) begin
    if (push) begin
      pc_mem[wr_ptr] <= fetch_pc;
      ins_mem[wr_ptr] <= i_INSTRUCTION;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb_fetch_prefetch_buffer: three configurations on shared stimulus, checked against a queue model
module tb_fetch_prefetch_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, en, redir, gnt, fn;
  logic [31:0] rpc, ins;
  logic r4, r8, rw, v4, v8, vw;
  logic [31:0] a4, a8, aw, i4, i8, iw, p4, p8, pw;
  logic [2:0] c4, cw;
  logic [3:0] c8;
  fetch_prefetch_buffer u4 (
    .i_CLK(clk), .i_RST(rst), .i_EN(en), .i_REDIRECT(redir), .i_REDIRECT_PC(rpc),
    .o_INSTRUCTION_REQ(r4), .o_INSTRUCTION_ADDR(a4), .i_INSTRUCTION_GNT(gnt), .i_INSTRUCTION(ins),
    .i_INSTRUCTION_FETCH_NEXT(fn), .o_INSTRUCTION(i4), .o_INSTRUCTION_PC(p4),
    .o_INSTRUCTION_VALID(v4), .o_COUNT(c4));
  fetch_prefetch_buffer #(.DEPTH(8)) u8 (
    .i_CLK(clk), .i_RST(rst), .i_EN(en), .i_REDIRECT(redir), .i_REDIRECT_PC(rpc),
    .o_INSTRUCTION_REQ(r8), .o_INSTRUCTION_ADDR(a8), .i_INSTRUCTION_GNT(gnt), .i_INSTRUCTION(ins),
    .i_INSTRUCTION_FETCH_NEXT(fn), .o_INSTRUCTION(i8), .o_INSTRUCTION_PC(p8),
    .o_INSTRUCTION_VALID(v8), .o_COUNT(c8));
  fetch_prefetch_buffer #(.RESET_PC(32'hFFFFFFF8)) uw (
    .i_CLK(clk), .i_RST(rst), .i_EN(en), .i_REDIRECT(redir), .i_REDIRECT_PC(rpc),
    .o_INSTRUCTION_REQ(rw), .o_INSTRUCTION_ADDR(aw), .i_INSTRUCTION_GNT(gnt), .i_INSTRUCTION(ins),
    .i_INSTRUCTION_FETCH_NEXT(fn), .o_INSTRUCTION(iw), .o_INSTRUCTION_PC(pw),
    .o_INSTRUCTION_VALID(vw), .o_COUNT(cw));
  int sel;
  logic s_req, s_valid;
  logic [31:0] s_addr, s_ins, s_pc;
  logic [3:0] s_count;
  always_comb begin
    s_req = sel == 1 ? r8 : sel == 2 ? rw : r4;
    s_valid = sel == 1 ? v8 : sel == 2 ? vw : v4;
    s_addr = sel == 1 ? a8 : sel == 2 ? aw : a4;
    s_ins = sel == 1 ? i8 : sel == 2 ? iw : i4;
    s_pc = sel == 1 ? p8 : sel == 2 ? pw : p4;
    s_count = sel == 1 ? c8 : sel == 2 ? {1'b0, cw} : {1'b0, c4};
  end
  int total = 0, passed = 0;
  int mdepth;
  logic [31:0] mpc, mrst_pc;
  logic [63:0] mq[$];
  logic e_req, e_valid;
  logic [31:0] e_addr, e_ins, e_pc;
  int e_count;
  task automatic attach(input int s, input int depth, input logic [31:0] rpc0);
    sel = s;
    mdepth = depth;
    mrst_pc = rpc0;
  endtask
  task automatic expect_now();
    e_req = en && !redir && (mq.size() < mdepth);
    e_addr = mpc;
    e_count = mq.size();
    e_valid = e_count != 0;
    e_ins = e_valid ? mq[0][31:0] : 32'h00000013;
    e_pc = e_valid ? mq[0][63:32] : 32'h0;
  endtask
  task automatic tick();
    logic push;
    push = en && gnt && (mq.size() < mdepth);
    if (rst) begin
      mq.delete();
      mpc = mrst_pc;
    end else if (redir) begin
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
    end else begin
      if (fn && mq.size() > 0) void'(mq.pop_front());
      if (push) begin
        mq.push_back({mpc, ins});
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    attach(0, 4, 32'h0);
    rst = 1; en = 1; redir = 0; gnt = 1; fn = 1; rpc = 32'h40; ins = $urandom;
    tick();
    rst = 0; gnt = 0; fn = 0;
    #1;
    total++; if (s_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", s_valid); else passed++;
    total++; if (s_ins !== 32'h13) $display("FAIL reset_ins got %h exp 00000013", s_ins); else passed++;
    total++; if (s_pc !== 32'h0) $display("FAIL reset_pc got %h exp 0", s_pc); else passed++;
    total++; if (s_addr !== 32'h0) $display("FAIL reset_addr got %h exp 0", s_addr); else passed++;
    total++; if (s_count !== 4'd0) $display("FAIL reset_count got %0d exp 0", s_count); else passed++;
    total++; if (s_req !== 1'b1) $display("FAIL reset_req_en1 got %b exp 1", s_req); else passed++;
    total++; if (aw !== 32'hFFFFFFF8) $display("FAIL reset_addr_param got %h exp fffffff8", aw); else passed++;
    en = 0;
    #1;
    total++; if (s_req !== 1'b0) $display("FAIL reset_req_en0 got %b exp 0", s_req); else passed++;
  endtask
  task automatic test_fill();
    logic [31:0] w [5];
    en = 1; gnt = 1; fn = 0;
    for (int k = 0; k < 5; k++) begin
      ins = $urandom;
      w[k] = ins;
      #1;
      total++; if (s_addr !== 32'(4 * (k < 4 ? k : 4))) $display("FAIL fill_addr k=%0d got %h exp %h", k, s_addr, 4 * (k < 4 ? k : 4)); else passed++;
      total++; if (s_count !== 4'(k)) $display("FAIL fill_count k=%0d got %0d exp %0d", k, s_count, k); else passed++;
      total++; if (s_req !== (k < 4)) $display("FAIL fill_req k=%0d got %b exp %b", k, s_req, k < 4); else passed++;
      tick();
    end
    total++; if (s_addr !== 32'd16) $display("FAIL full_gnt_ignored_addr got %h exp 10", s_addr); else passed++;
    total++; if (s_count !== 4'd4) $display("FAIL full_gnt_ignored_count got %0d exp 4", s_count); else passed++;
    total++; if (s_ins !== w[0]) $display("FAIL fill_head_ins got %h exp %h", s_ins, w[0]); else passed++;
    total++; if (s_pc !== 32'h0) $display("FAIL fill_head_pc got %h exp 0", s_pc); else passed++;
  endtask
  task automatic test_stream();
    logic [31:0] nexp = 32'h0;
    en = 1; gnt = 1; fn = 1;
    for (int i = 0; i < 12; i++) begin
      ins = $urandom;
      expect_now();
      #1;
      total++; if (s_req !== (i != 0)) $display("FAIL stream_req cyc %0d got %b exp %b", i, s_req, i != 0); else passed++;
      total++; if (s_valid !== 1'b1 || s_pc !== nexp) $display("FAIL stream_order cyc %0d got v=%b pc=%h exp v=1 pc=%h", i, s_valid, s_pc, nexp); else passed++;
      total++; if (s_ins !== e_ins || s_count !== 4'(e_count)) $display("FAIL stream_head cyc %0d got ins=%h cnt=%0d exp ins=%h cnt=%0d", i, s_ins, s_count, e_ins, e_count); else passed++;
      nexp = nexp + 32'd4;
      tick();
    end
  endtask
  task automatic test_redirect();
    en = 1; gnt = 0; fn = 1;
    for (int i = 0; i < 8 && mq.size() != 2; i++) tick();
    #1;
    total++; if (s_count !== 4'd2) $display("FAIL redir_pre_count got %0d exp 2", s_count); else passed++;
    redir = 1; rpc = 32'h00000103; gnt = 1; fn = 1; ins = $urandom;
    #1;
    total++; if (s_req !== 1'b0) $display("FAIL redir_req got %b exp 0", s_req); else passed++;
    tick();
    redir = 0; gnt = 0; fn = 0;
    #1;
    total++; if (s_count !== 4'd0) $display("FAIL redir_count got %0d exp 0", s_count); else passed++;
    total++; if (s_addr !== 32'h100) $display("FAIL redir_addr got %h exp 00000100", s_addr); else passed++;
    total++; if (s_valid !== 1'b0) $display("FAIL redir_valid got %b exp 0", s_valid); else passed++;
    total++; if (s_ins !== 32'h13) $display("FAIL redir_ins got %h exp 00000013", s_ins); else passed++;
  endtask
  task automatic test_wrap();
    attach(2, 4, 32'hFFFFFFF8);
    rst = 1; tick();
    rst = 0; en = 1; gnt = 1; fn = 0; ins = $urandom;
    #1;
    total++; if (s_addr !== 32'hFFFFFFF8) $display("FAIL wrap_addr0 got %h exp fffffff8", s_addr); else passed++;
    tick();
    ins = $urandom;
    total++; if (s_addr !== 32'hFFFFFFFC) $display("FAIL wrap_addr1 got %h exp fffffffc", s_addr); else passed++;
    tick();
    total++; if (s_addr !== 32'h0) $display("FAIL wrap_addr2 got %h exp 0", s_addr); else passed++;
    total++; if (s_pc !== 32'hFFFFFFF8) $display("FAIL wrap_head0 got %h exp fffffff8", s_pc); else passed++;
    gnt = 0; fn = 1;
    tick();
    total++; if (s_pc !== 32'hFFFFFFFC) $display("FAIL wrap_head1 got %h exp fffffffc", s_pc); else passed++;
  endtask
  task automatic test_random();
    attach(1, 8, 32'h0);
    rst = 1; redir = 0; tick();
    rst = 0;
    for (int i = 0; i < 500; i++) begin
      en = $urandom_range(0, 9) != 0;
      gnt = $urandom_range(0, 1) == 1;
      fn = $urandom_range(0, 2) == 0;
      redir = $urandom_range(0, 59) == 0;
      rpc = $urandom;
      ins = $urandom;
      expect_now();
      #1;
      total++;
      if ({s_req, s_valid, s_count, s_addr, s_pc, s_ins} !== {e_req, e_valid, 4'(e_count), e_addr, e_pc, e_ins})
        $display("FAIL rnd cyc %0d got req=%b v=%b cnt=%0d addr=%h pc=%h ins=%h exp req=%b v=%b cnt=%0d addr=%h pc=%h ins=%h",
                 i, s_req, s_valid, s_count, s_addr, s_pc, s_ins, e_req, e_valid, e_count, e_addr, e_pc, e_ins);
      else passed++;
      tick();
    end
    redir = 0;
  endtask
  task automatic test_reset_mid();
    attach(0, 4, 32'h0);
    rst = 1; tick();
    rst = 0; en = 1; gnt = 1; fn = 0;
    for (int i = 0; i < 3; i++) begin
      ins = $urandom;
      tick();
    end
    total++; if (s_count !== 4'd3) $display("FAIL rstmid_pre_count got %0d exp 3", s_count); else passed++;
    rst = 1; redir = 1; rpc = 32'h200; fn = 1;
    tick();
    rst = 0; redir = 0; gnt = 0; fn = 0;
    #1;
    total++; if (s_count !== 4'd0) $display("FAIL rstmid_count got %0d exp 0", s_count); else passed++;
    total++; if (s_addr !== 32'h0) $display("FAIL rstmid_addr got %h exp 0", s_addr); else passed++;
    total++; if (s_valid !== 1'b0) $display("FAIL rstmid_valid got %b exp 0", s_valid); else passed++;
  endtask
  initial begin
    rst = 1; en = 0; redir = 0; gnt = 0; fn = 0; rpc = 0; ins = 0;
    sel = 0; mdepth = 4; mpc = 0; mrst_pc = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_stream();
    test_redirect();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
